// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit adder/subtractor, one carry-chain slice per register stage,
// valid/ready handshake with a single global advance enable.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;
    for (genvar k = 0; k < STAGES; k++) begin : g
        // ia/ib hold the operand bits not yet added; r accumulates the finished low slices
        localparam int IW = WIDTH - k * SW;
        localparam int LW = (k + 1) * SW;
        logic [IW-1:0] ia, ib;
        logic [LW-1:0] nr, r;
        logic [SW:0]   s;
        logic          xc, xv, xam, xbm, c, v, am, bm;
        if (k == 0) begin : first
            assign ia  = a;
            assign ib  = b_eff;
            assign xc  = c0;
            assign xv  = in_valid;
            assign xam = a[WIDTH-1];
            assign xbm = b_eff[WIDTH-1];
            assign nr  = s[SW-1:0];
        end else begin : next
            assign ia  = g[k-1].rem.ra;
            assign ib  = g[k-1].rem.rb;
            assign xc  = g[k-1].c;
            assign xv  = g[k-1].v;
            assign xam = g[k-1].am;
            assign xbm = g[k-1].bm;
            assign nr  = {s[SW-1:0], g[k-1].r};
        end
        assign s = {1'b0, ia[SW-1:0]} + {1'b0, ib[SW-1:0]} + {{SW{1'b0}}, xc};
        always_ff @(posedge clk)
            if (rst)
                {v, c, am, bm, r} <= '0;
            else if (en)
                {v, c, am, bm, r} <= {xv, s[SW], xam, xbm, nr};
        if (IW > SW) begin : rem
            logic [IW-SW-1:0] ra, rb;
            always_ff @(posedge clk)
                if (en) begin
                    ra <= ia[IW-1:SW];
                    rb <= ib[IW-1:SW];
                end
        end
    end
    assign out_valid = g[STAGES-1].v;
    assign sum       = g[STAGES-1].r;
    assign cout      = g[STAGES-1].c;
    assign ovf       = (g[STAGES-1].am == g[STAGES-1].bm) && (sum[WIDTH-1] != g[STAGES-1].am);
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed checks of a 16-bit/4-stage instance and an exhaustive
// 4-bit/2-stage instance against hand values and a small reference function.
module tb_pipe_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        iv = 1'b0, ordy = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir, ov, co, of;
    logic [15:0] s16;
    logic [17:0] nx = '0;
    logic [17:0] q16[$];

    logic        iv4 = 1'b0, ordy4 = 1'b1, cin4 = 1'b0, sub4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ir4, ov4, co4, of4;
    logic [3:0]  s4;
    logic [5:0]  nx4 = '0;
    logic [5:0]  q4[$];

    int nchk = 0, nerr = 0;

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16),
        .cin(cin), .sub(sub), .out_valid(ov), .out_ready(ordy), .sum(s16),
        .cout(co), .ovf(of)
    );

    pipe_addsub #(.WIDTH(4), .STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(ordy4), .sum(s4),
        .cout(co4), .ovf(of4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {cout, ovf, sum} straight from the arithmetic definition
    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c, input logic s);
        logic [3:0] be;
        logic [4:0] t;
        be = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + {4'b0, s | c};
        return {t[4], (x[3] == be[3]) && (t[3] != x[3]), t[3:0]};
    endfunction

    task automatic step();
        #1;
        if (!rst) begin
            if (ov && ordy) begin
                check("qlen16", q16.size() > 0, 1);
                if (q16.size() > 0) check("res16", {co, of, s16}, q16.pop_front());
            end
            if (iv && ir) q16.push_back(nx);
        end
        @(posedge clk);
        #1;
        if (rst) q16.delete();
    endtask

    task automatic step4(output bit acc);
        #1;
        acc = iv4 && ir4;
        if (ov4 && ordy4) begin
            check("qlen4", q4.size() > 0, 1);
            if (q4.size() > 0) check("res4", {co4, of4, s4}, q4.pop_front());
        end
        if (acc) q4.push_back(nx4);
        @(posedge clk);
        #1;
        ordy4 = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c,
                         input logic s, input logic [17:0] e);
        iv = 1'b1; a16 = x; b16 = y; cin = c; sub = s; nx = e;
    endtask

    task automatic drain16();
        int n = 0;
        iv = 1'b0;
        while (q16.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain16", q16.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] st[8];
        bit acc;
        int i, cyc, stall_left, n;
        bit stall_done;
        st = '{18'h00000, 18'h01002, 18'h02002, 18'h03004,
               18'h04004, 18'h05006, 18'h06006, 18'h07008};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_ov", ov, 0);
        check("rst_sum", s16, 0);
        check("rst_cout", co, 0);
        check("rst_ovf", of, 0);
        check("rst_ir", ir, 1);
        check("rst_ov4", ov4, 0);
        ordy = 1'b1;

        // carry out of the top bit, latency of STAGES cycles
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h20000);
        step();
        iv = 1'b0;
        step();
        check("lat_t1", ov, 0);
        step();
        check("lat_t2", ov, 0);
        step();
        check("lat_t3", ov, 1);
        drain16();

        // back-to-back with signed overflow both ways
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000);
        step();
        drive(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
        step();
        iv = 1'b0;
        step();
        step();
        check("b2b_first", ov, 1);
        step();
        check("b2b_second", ov, 1);
        drain16();

        // 8-operation stream with a 3-cycle consumer stall
        i = 0; cyc = 0; stall_left = 0; stall_done = 0;
        while ((i < 8 || q16.size() > 0) && cyc < 200) begin
            if (i < 8) drive(16'(i), 16'(i * 16'h1000), i[0], 1'b0, st[i]);
            else iv = 1'b0;
            if (ov && !stall_done) begin
                stall_left = 3;
                stall_done = 1;
            end
            ordy = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_ir", ir, 0);
                check("stall_frozen", {ov, co, of, s16}, 19'h40000);
            end
            step();
            if (stall_left > 0) stall_left--;
            else if (iv) i++;
            cyc++;
        end
        check("stream_sent", i, 8);
        check("stream_left", q16.size(), 0);
        ordy = 1'b1;

        // reset with three operations in flight
        for (int j = 0; j < 3; j++) begin
            drive(16'(j + 1), 16'h0100, 1'b0, 1'b0, 18'h0);
            step();
        end
        drive(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h0);
        rst = 1'b1;
        ordy = 1'b0;
        step();
        rst = 1'b0;
        iv = 1'b0;
        #1;
        check("mid_rst_ov", ov, 0);
        check("mid_rst_sum", s16, 0);
        check("mid_rst_ir", ir, 1);
        ordy = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check("post_rst_ov", ov, 0);
        end

        // bubbles pass through uncompressed
        for (int j = 0; j < 4; j++) begin
            if (j == 0) drive(16'd1, 16'd2, 1'b0, 1'b0, 18'h00003);
            else if (j == 3) drive(16'd5, 16'd5, 1'b0, 1'b0, 18'h0000A);
            else iv = 1'b0;
            step();
        end
        iv = 1'b0;
        check("bub_0", ov, 1);
        step();
        check("bub_1", ov, 0);
        step();
        check("bub_2", ov, 0);
        step();
        check("bub_3", ov, 1);
        drain16();

        // exhaustive 4-bit instance under random backpressure
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    for (int si = 0; si < 2; si++) begin
                        iv4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); cin4 = ci[0]; sub4 = si[0];
                        nx4 = ref4(a4, b4, cin4, sub4);
                        n = 0;
                        acc = 0;
                        while (!acc && n < 50) begin
                            step4(acc);
                            n++;
                        end
                        if (!acc) check("acc4_timeout", n, 0);
                    end
        iv4 = 1'b0;
        n = 0;
        while (q4.size() > 0 && n < 200) begin
            step4(acc);
            n++;
        end
        check("drain4", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
